keyboard_receiver: RTL and testbench

KEYBOARD_RECEIVER -- requirements
Module: keyboard_receiver

---
 rtl/keyboard_receiver.sv | 186 ++++++++++++++++++
 tb/tb_keyboard_receiver.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/keyboard_receiver.sv
// PS/2 keyboard receiver: synchronizes the raw PS/2 bus, decodes 11-bit frames
// with odd parity and queues scan codes in a small FIFO for a KBSR/KBDR pair.
module keyboard_receiver #(
  parameter int unsigned TIMEOUT_CYCLES = 50000,
  parameter int unsigned DEPTH          = 4
) (
  input  logic        Clk,
  input  logic        Reset_N,
  input  logic        PS2_CLK,
  input  logic        PS2_DAT,
  input  logic        Read,
  output logic [15:0] Data_FromKeyboard,
  output logic        Ready,
  output logic        Overflow,
  output logic        Error
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_e;

  state_e             state_q, state_d;
  logic [2:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               par_ok_q, par_ok_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [7:0]         mem_q [DEPTH];
  logic [7:0]         mem_d [DEPTH];
  logic               overflow_q, overflow_d;
  logic               error_q, error_d;

  logic clk_meta_q, clk_meta_d;
  logic clk_sync_q, clk_sync_d;
  logic clk_prev_q, clk_prev_d;
  logic dat_meta_q, dat_meta_d;
  logic dat_sync_q, dat_sync_d;

  logic fall;
  logic dat;
  logic push_req;
  logic error_set;
  logic full;
  logic empty;
  logic pop;
  logic push_ok;
  logic ovf_set;

  // Next-state logic: synchronizers, frame FSM, timeout, FIFO and sticky flags
  always_comb begin
    clk_meta_d = PS2_CLK;
    clk_sync_d = clk_meta_q;
    clk_prev_d = clk_sync_q;
    dat_meta_d = PS2_DAT;
    dat_sync_d = dat_meta_q;

    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_ok_d  = par_ok_q;
    tmo_d     = tmo_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    mem_d     = mem_q;
    push_req  = 1'b0;
    error_set = 1'b0;

    fall = ~clk_sync_q & clk_prev_q;
    dat  = dat_sync_q;

    case (state_q)
      IDLE: begin
        if (fall && !dat) begin
          state_d   = DATA;
          bit_cnt_d = 3'd0;
        end
      end
      DATA: begin
        if (fall) begin
          shift_d = {dat, shift_q[7:1]};
          if (bit_cnt_q == 3'd7) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + 3'd1;
          end
        end
      end
      PARITY: begin
        if (fall) begin
          par_ok_d = ^{shift_q, dat};
          state_d  = STOP;
        end
      end
      STOP: begin
        if (fall) begin
          if (dat && par_ok_q) begin
            push_req = 1'b1;
          end else begin
            error_set = 1'b1;
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled keyboard drops the partial frame without flagging an error
    if (state_q == IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1)) begin
      tmo_d   = '0;
      state_d = IDLE;
    end else begin
      tmo_d = tmo_q + TMO_W'(1);
    end

    full    = (count_q == CNT_W'(DEPTH));
    empty   = (count_q == '0);
    pop     = Read & ~empty;
    push_ok = push_req & (~full | pop);
    ovf_set = push_req & full & ~pop;

    if (push_ok) begin
      mem_d[wr_ptr_q] = shift_q;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);

    // Set wins over the Read clear on the same edge
    overflow_d = ovf_set | (overflow_q & ~Read);
    error_d    = error_set | (error_q & ~Read);
  end

  always_ff @(posedge Clk or negedge Reset_N) begin
    if (!Reset_N) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
      state_q    <= IDLE;
      bit_cnt_q  <= 3'd0;
      shift_q    <= 8'h00;
      par_ok_q   <= 1'b0;
      tmo_q      <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      error_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 8'h00;
      end
    end else begin
      clk_meta_q <= clk_meta_d;
      clk_sync_q <= clk_sync_d;
      clk_prev_q <= clk_prev_d;
      dat_meta_q <= dat_meta_d;
      dat_sync_q <= dat_sync_d;
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_ok_q   <= par_ok_d;
      tmo_q      <= tmo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      error_q    <= error_d;
      mem_q      <= mem_d;
    end
  end

  assign Ready             = (count_q != '0);
  assign Data_FromKeyboard = Ready ? {8'h00, mem_q[rd_ptr_q]} : 16'h0000;
  assign Overflow          = overflow_q;
  assign Error             = error_q;

endmodule

// File: tb/tb_keyboard_receiver.sv
// Directed bench for keyboard_receiver: a table of whole frames with expected
// status, plus hand-written sequences for latency, full-FIFO, timeout and reset.
module tb_keyboard_receiver;

  localparam int HALF = 8;

  logic        Clk = 1'b0;
  logic        Reset_N;
  logic        PS2_CLK;
  logic        PS2_DAT;
  logic        Read;
  logic [15:0] Data_FromKeyboard;
  logic        Ready;
  logic        Overflow;
  logic        Error;

  int n_checks = 0;
  int n_fail   = 0;

  keyboard_receiver dut (
    .Clk               (Clk),
    .Reset_N           (Reset_N),
    .PS2_CLK           (PS2_CLK),
    .PS2_DAT           (PS2_DAT),
    .Read              (Read),
    .Data_FromKeyboard (Data_FromKeyboard),
    .Ready             (Ready),
    .Overflow          (Overflow),
    .Error             (Error)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [7:0]  d;
    logic        p;
    logic        s;
    logic        rd;
    logic        exp_ready;
    logic [15:0] exp_data;
    logic        exp_err;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs [8];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge Clk);
  endtask

  task automatic ps2_bit(input logic b);
    @(negedge Clk);
    PS2_DAT = b;
    cyc(HALF);
    PS2_CLK = 1'b0;
    cyc(HALF);
    PS2_CLK = 1'b1;
  endtask

  task automatic send_head(input logic [7:0] d, input logic p);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    send_head(d, p);
    ps2_bit(s);
    cyc(2);
  endtask

  task automatic do_read();
    @(negedge Clk);
    Read = 1'b1;
    @(negedge Clk);
    Read = 1'b0;
  endtask

  function automatic logic odd_par(input logic [7:0] d);
    return ~^d;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit found;
    logic [7:0] b;

    vecs[0] = '{8'hA5, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A5, 1'b0, 1'b0};
    vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{8'h1C, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[3] = '{8'h01, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[4] = '{8'h02, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[5] = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[6] = '{8'h04, 1'b0, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b0};
    vecs[7] = '{8'h05, 1'b1, 1'b1, 1'b0, 1'b1, 16'h0001, 1'b0, 1'b1};

    Reset_N = 1'b0;
    PS2_CLK = 1'b1;
    PS2_DAT = 1'b1;
    Read    = 1'b0;
    cyc(3);
    chk("reset_ready", 16'(Ready), 16'h0);
    chk("reset_data", Data_FromKeyboard, 16'h0000);
    chk("reset_ovf", 16'(Overflow), 16'h0);
    chk("reset_err", 16'(Error), 16'h0);
    Reset_N = 1'b1;
    cyc(2);
    chk("post_reset_ready", 16'(Ready), 16'h0);

    // Stop-bit fall to Ready latency on frame 0x1C
    send_head(8'h1C, 1'b0);
    @(negedge Clk);
    PS2_DAT = 1'b1;
    cyc(HALF);
    PS2_CLK = 1'b0;
    lat = 0;
    found = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      @(negedge Clk);
      if (Ready && !found) begin
        found = 1'b1;
        lat = k;
      end
    end
    chk("stop_to_ready_le4", 16'(found && lat <= 4), 16'h1);
    cyc(HALF);
    PS2_CLK = 1'b1;
    cyc(2);
    chk("frame1c_data", Data_FromKeyboard, 16'h001C);
    chk("frame1c_err", 16'(Error), 16'h0);
    do_read();
    chk("frame1c_empty", 16'(Ready), 16'h0);

    // Table of whole frames
    for (int i = 0; i < 8; i++) begin
      send_frame(vecs[i].d, vecs[i].p, vecs[i].s);
      chk($sformatf("vec%0d_ready", i), 16'(Ready), 16'(vecs[i].exp_ready));
      chk($sformatf("vec%0d_data", i), Data_FromKeyboard, vecs[i].exp_data);
      chk($sformatf("vec%0d_err", i), 16'(Error), 16'(vecs[i].exp_err));
      chk($sformatf("vec%0d_ovf", i), 16'(Overflow), 16'(vecs[i].exp_ovf));
      if (vecs[i].rd) begin
        do_read();
        chk($sformatf("vec%0d_err_clr", i), 16'(Error), 16'h0);
        chk($sformatf("vec%0d_rd_empty", i), 16'(Ready), 16'h0);
      end
    end

    // Drain the overflowed FIFO in order
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("drain%0d_data", k), Data_FromKeyboard, 16'(k + 1));
      do_read();
      chk($sformatf("drain%0d_ovf", k), 16'(Overflow), 16'h0);
    end
    chk("drain_empty_ready", 16'(Ready), 16'h0);
    chk("drain_empty_data", Data_FromKeyboard, 16'h0000);
    do_read();
    chk("underflow_ready", 16'(Ready), 16'h0);

    // Refill to full, then push 0x05 on the same edge as a Read
    for (int k = 1; k <= 4; k++) begin
      b = 8'(k);
      send_frame(b, odd_par(b), 1'b1);
    end
    chk("refill_head", Data_FromKeyboard, 16'h0001);
    chk("refill_ovf", 16'(Overflow), 16'h0);
    send_head(8'h05, 1'b1);
    @(negedge Clk);
    PS2_DAT = 1'b1;
    cyc(HALF);
    PS2_CLK = 1'b0;
    cyc(2);
    Read = 1'b1;
    @(negedge Clk);
    Read = 1'b0;
    cyc(HALF);
    PS2_CLK = 1'b1;
    cyc(2);
    chk("simul_ovf", 16'(Overflow), 16'h0);
    for (int k = 2; k <= 5; k++) begin
      chk($sformatf("simul_pop%0d", k), Data_FromKeyboard, 16'(k));
      do_read();
    end
    chk("simul_empty", 16'(Ready), 16'h0);

    // Partial frame, stall past the timeout, then a full frame
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    ps2_bit(1'b0);
    ps2_bit(1'b1);
    cyc(50010);
    send_frame(8'hF0, 1'b1, 1'b1);
    chk("timeout_ready", 16'(Ready), 16'h1);
    chk("timeout_data", Data_FromKeyboard, 16'h00F0);
    chk("timeout_err", 16'(Error), 16'h0);
    do_read();
    chk("timeout_single", 16'(Ready), 16'h0);

    // Reset mid-frame with a byte already queued
    send_frame(8'h33, 1'b1, 1'b1);
    chk("prereset_ready", 16'(Ready), 16'h1);
    ps2_bit(1'b0);
    for (int k = 0; k < 5; k++) ps2_bit(1'(k & 1));
    @(negedge Clk);
    Reset_N = 1'b0;
    cyc(1);
    chk("midreset_ready", 16'(Ready), 16'h0);
    chk("midreset_data", Data_FromKeyboard, 16'h0000);
    cyc(3);
    Reset_N = 1'b1;
    cyc(2);
    send_frame(8'h5A, 1'b1, 1'b1);
    chk("afterreset_data", Data_FromKeyboard, 16'h005A);
    chk("afterreset_err", 16'(Error), 16'h0);
    do_read();
    chk("afterreset_single", 16'(Ready), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
